mac_iter_unit: RTL and testbench

- Iterative multiply-accumulate responder serving the integer datapath's Execute stage.
- The datapath issues a MAC request with its ALU operands. This block accepts it and computes the product over several cycles at a configurable number of bits per cycle.
- It holds the hazard unit stalled while busy, then returns the updated accumulator to the Execute-stage result mux.
- It also serves clear and read requests for the accumulator.

---
 rtl/mac_iter_unit_if.sv | 27 ++
 rtl/mac_iter_unit.sv | 137 +++++++++++++
 tb/tb_mac_iter_unit.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_iter_unit_if.sv
// Execute-stage request/response bundle between the integer datapath and the
// iterative MAC unit. The datapath side drives requests, the unit answers.
interface mac_iter_unit_if #(
    parameter int XLEN = 64
);
    logic            ValidE;
    logic [1:0]      OpE;
    logic [XLEN-1:0] SrcAE;
    logic [XLEN-1:0] SrcBE;
    logic            StallE;
    logic            FlushE;
    logic            BusyE;
    logic            DoneE;
    logic [XLEN-1:0] MacResultE;

    // Datapath / pipeline side of the link
    modport master (
        output ValidE, OpE, SrcAE, SrcBE, StallE, FlushE,
        input  BusyE, DoneE, MacResultE
    );

    // MAC unit side of the link
    modport slave (
        input  ValidE, OpE, SrcAE, SrcBE, StallE, FlushE,
        output BusyE, DoneE, MacResultE
    );
endinterface

// File: rtl/mac_iter_unit.sv
// Iterative multiply-accumulate responder for the Execute stage.
// A MAC request latches its operands, retires BPC multiplier bits per cycle
// into a partial product, folds the partial into the accumulator, then
// presents the accumulator until the pipeline takes it. CLR and RD answer
// in a single cycle. Only the low XLEN bits of every product are kept, so
// signed and unsigned operands give the same result.
module mac_iter_unit #(
    parameter int XLEN = 64,
    parameter int BPC  = 4
) (
    input  logic          clk,
    input  logic          reset,
    mac_iter_unit_if.slave bus
);

    localparam int N  = XLEN / BPC;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int SW = (XLEN > 1) ? $clog2(XLEN) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        ACC,
        DONE
    } state_t;

    state_t          stateQ, stateD;
    logic [XLEN-1:0] aQ, aD;
    logic [XLEN-1:0] bQ, bD;
    logic [XLEN-1:0] partialQ, partialD;
    logic [CW-1:0]   countQ, countD;
    logic [XLEN-1:0] accQ, accD;

    logic            accept;
    logic [XLEN-1:0] digitProd;
    logic [SW-1:0]   shiftAmt;

    // A request is taken only when it is present and not being flushed away.
    assign accept = bus.ValidE & ~bus.FlushE;

    // Product of the multiplicand with the current low multiplier digit,
    // weighted by the digit's position in the original multiplier.
    assign digitProd = aQ * {{(XLEN - BPC){1'b0}}, bQ[BPC-1:0]};
    assign shiftAmt  = SW'(countQ) * SW'(BPC);

    // State and datapath registers; reset discards any work in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateQ   <= IDLE;
            aQ       <= '0;
            bQ       <= '0;
            partialQ <= '0;
            countQ   <= '0;
            accQ     <= '0;
        end else begin
            stateQ   <= stateD;
            aQ       <= aD;
            bQ       <= bD;
            partialQ <= partialD;
            countQ   <= countD;
            accQ     <= accD;
        end
    end

    // Next-state and datapath update: flush always wins over stall, and a
    // flush during ACC suppresses the accumulator write.
    always_comb begin
        stateD   = stateQ;
        aD       = aQ;
        bD       = bQ;
        partialD = partialQ;
        countD   = countQ;
        accD     = accQ;

        case (stateQ)
            IDLE: begin
                if (accept) begin
                    case (bus.OpE)
                        2'b00: begin
                            aD       = bus.SrcAE;
                            bD       = bus.SrcBE;
                            partialD = '0;
                            countD   = '0;
                            stateD   = MUL;
                        end
                        2'b01: begin
                            accD   = '0;
                            stateD = DONE;
                        end
                        default: begin
                            stateD = DONE;
                        end
                    endcase
                end
            end
            MUL: begin
                if (bus.FlushE) begin
                    stateD = IDLE;
                end else begin
                    partialD = partialQ + (digitProd << shiftAmt);
                    bD       = bQ >> BPC;
                    countD   = countQ + CW'(1);
                    if (countQ == LAST_COUNT) begin
                        stateD = ACC;
                    end
                end
            end
            ACC: begin
                if (bus.FlushE) begin
                    stateD = IDLE;
                end else begin
                    accD   = accQ + partialQ;
                    stateD = DONE;
                end
            end
            DONE: begin
                if (bus.FlushE || !bus.StallE) begin
                    stateD = IDLE;
                end
            end
            default: begin
                stateD = IDLE;
            end
        endcase
    end

    // Handshake outputs: busy freezes the pipeline from the accept cycle
    // onward, and the result is only driven while DONE is held.
    always_comb begin
        bus.BusyE      = (stateQ == MUL) || (stateQ == ACC) ||
                         ((stateQ == IDLE) && accept);
        bus.DoneE      = (stateQ == DONE);
        bus.MacResultE = (stateQ == DONE) ? accQ : '0;
    end

endmodule

// File: tb/tb_mac_iter_unit.sv
// Self-checking bench for mac_iter_unit. The reference model keeps the
// accumulator as a plain 64-bit number and applies acc + a*b, clear or read
// per request; latencies come straight from the request type.
module tb_mac_iter_unit;

    localparam int XLEN = 64;
    localparam int BPC  = 4;
    localparam int N    = XLEN / BPC;

    logic clk = 1'b0;
    logic reset;

    int checkCount = 0;
    int passCount  = 0;
    logic [XLEN-1:0] modelAcc;

    mac_iter_unit_if #(.XLEN(XLEN)) bus ();

    mac_iter_unit #(.XLEN(XLEN), .BPC(BPC)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // Free-running clock, period 10
    always #5 clk = ~clk;

    // Drives one request the way the pipeline would: the request is held
    // while the unit works, stalled for 'stall' DONE cycles, and optionally
    // flushed in cycle 'flushAt' (cycle 0 is the accept cycle). Outputs are
    // sampled on the falling edge.
    task automatic applyStimulus(input logic [1:0] op, input logic [XLEN-1:0] a,
                                 input logic [XLEN-1:0] b, input int stall,
                                 input int flushAt, input bit scramble,
                                 output int doneCycle, output int doneCnt,
                                 output int busyCnt, output logic [XLEN-1:0] result,
                                 output bit stable);
        int  c;
        bit  finished;
        doneCycle = -1;
        doneCnt   = 0;
        busyCnt   = 0;
        result    = '0;
        stable    = 1'b1;
        c         = 0;
        finished  = 1'b0;
        bus.ValidE = 1'b1;
        bus.OpE    = op;
        bus.SrcAE  = a;
        bus.SrcBE  = b;
        bus.StallE = (stall > 0);
        bus.FlushE = 1'b0;
        while (!finished && c < 300) begin
            bus.FlushE = (c == flushAt);
            if (flushAt >= 0 && c > flushAt) bus.ValidE = 1'b0;
            if (scramble && c > 0) begin
                bus.SrcAE = {$urandom, $urandom};
                bus.SrcBE = {$urandom, $urandom};
            end
            @(negedge clk);
            if (bus.BusyE === 1'b1) busyCnt++;
            if (bus.DoneE === 1'b1) begin
                doneCnt++;
                if (doneCnt == 1) begin
                    doneCycle = c;
                    result    = bus.MacResultE;
                end else if (bus.MacResultE !== result) begin
                    stable = 1'b0;
                end
                if (doneCnt > stall) begin
                    bus.StallE = 1'b0;
                    finished   = 1'b1;
                end
            end
            if (flushAt >= 0 && c >= flushAt + 3) finished = 1'b1;
            @(posedge clk);
            #1;
            c++;
        end
        bus.ValidE = 1'b0;
        bus.StallE = 1'b0;
        bus.FlushE = 1'b0;
    endtask

    // Reset values, then a read of the cleared accumulator
    task automatic test_reset();
        int dc, dn, bc;
        logic [XLEN-1:0] r;
        bit st;
        reset      = 1'b1;
        bus.ValidE = 1'b0;
        bus.OpE    = 2'b00;
        bus.SrcAE  = '0;
        bus.SrcBE  = '0;
        bus.StallE = 1'b0;
        bus.FlushE = 1'b0;
        #12;
        checkCount++;
        if (bus.BusyE !== 1'b0) $display("[TB] FAIL reset_busy got=%b want=0", bus.BusyE);
        else passCount++;
        checkCount++;
        if (bus.DoneE !== 1'b0) $display("[TB] FAIL reset_done got=%b want=0", bus.DoneE);
        else passCount++;
        checkCount++;
        if (bus.MacResultE !== '0) $display("[TB] FAIL reset_result got=%h want=0", bus.MacResultE);
        else passCount++;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        modelAcc = '0;

        applyStimulus(2'b10, '0, '0, 0, -1, 1'b0, dc, dn, bc, r, st);
        checkCount++;
        if (dc !== 1) $display("[TB] FAIL rd_latency got=%0d want=1", dc);
        else passCount++;
        checkCount++;
        if (r !== modelAcc) $display("[TB] FAIL rd_after_reset got=%h want=%h", r, modelAcc);
        else passCount++;
        checkCount++;
        if (bc !== 1) $display("[TB] FAIL rd_busy_cycles got=%0d want=1", bc);
        else passCount++;
    endtask

    // Two back-to-back MACs with small operands
    task automatic test_mac_sequence();
        int dc, dn, bc;
        logic [XLEN-1:0] r;
        bit st;
        logic [XLEN-1:0] opA [2];
        logic [XLEN-1:0] opB [2];
        opA[0] = 64'd3; opB[0] = 64'd5;
        opA[1] = 64'd7; opB[1] = 64'd6;
        for (int i = 0; i < 2; i++) begin
            applyStimulus(2'b00, opA[i], opB[i], 0, -1, 1'b0, dc, dn, bc, r, st);
            modelAcc = modelAcc + opA[i] * opB[i];
            checkCount++;
            if (dc !== N + 2) $display("[TB] FAIL mac_latency[%0d] got=%0d want=%0d", i, dc, N + 2);
            else passCount++;
            checkCount++;
            if (r !== modelAcc) $display("[TB] FAIL mac_result[%0d] got=%h want=%h", i, r, modelAcc);
            else passCount++;
            checkCount++;
            if (bc !== N + 2) $display("[TB] FAIL mac_busy_cycles[%0d] got=%0d want=%0d", i, bc, N + 2);
            else passCount++;
        end
    endtask

    // Product truncation and accumulator wrap
    task automatic test_wrap();
        int dc, dn, bc;
        logic [XLEN-1:0] r;
        logic [XLEN-1:0] allOnes;
        bit st;
        allOnes = '1;
        applyStimulus(2'b01, '0, '0, 0, -1, 1'b0, dc, dn, bc, r, st);
        modelAcc = '0;
        checkCount++;
        if (r !== modelAcc || dc !== 1)
            $display("[TB] FAIL clr_result got=%h@%0d want=%h@1", r, dc, modelAcc);
        else passCount++;
        applyStimulus(2'b00, 64'd1, 64'd1, 0, -1, 1'b0, dc, dn, bc, r, st);
        modelAcc = modelAcc + 64'd1;
        applyStimulus(2'b00, allOnes, 64'd2, 0, -1, 1'b0, dc, dn, bc, r, st);
        modelAcc = modelAcc + allOnes * 64'd2;
        checkCount++;
        if (r !== allOnes) $display("[TB] FAIL wrap_result got=%h want=%h", r, allOnes);
        else passCount++;
    endtask

    // Flush in MUL and in ACC abandons the op and leaves the accumulator alone
    task automatic test_flush();
        int dc, dn, bc;
        logic [XLEN-1:0] r;
        bit st;
        int flushPoint [2];
        flushPoint[0] = 5;
        flushPoint[1] = N + 1;
        for (int i = 0; i < 2; i++) begin
            applyStimulus(2'b00, {$urandom, $urandom}, {$urandom, $urandom}, 0,
                          flushPoint[i], 1'b0, dc, dn, bc, r, st);
            checkCount++;
            if (dn !== 0) $display("[TB] FAIL flush_no_done[%0d] got=%0d want=0", i, dn);
            else passCount++;
            checkCount++;
            if (bc !== flushPoint[i] + 1)
                $display("[TB] FAIL flush_busy_cycles[%0d] got=%0d want=%0d", i, bc, flushPoint[i] + 1);
            else passCount++;
            applyStimulus(2'b10, '0, '0, 0, -1, 1'b0, dc, dn, bc, r, st);
            checkCount++;
            if (r !== modelAcc) $display("[TB] FAIL flush_acc_kept[%0d] got=%h want=%h", i, r, modelAcc);
            else passCount++;
        end
    endtask

    // Result held through a 3-cycle stall, no retrigger from the held request
    task automatic test_stall();
        int dc, dn, bc;
        logic [XLEN-1:0] r;
        logic [XLEN-1:0] a, b;
        bit st;
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        applyStimulus(2'b00, a, b, 3, -1, 1'b0, dc, dn, bc, r, st);
        modelAcc = modelAcc + a * b;
        checkCount++;
        if (dn !== 4) $display("[TB] FAIL stall_done_cycles got=%0d want=4", dn);
        else passCount++;
        checkCount++;
        if (st !== 1'b1) $display("[TB] FAIL stall_result_stable got=%b want=1", st);
        else passCount++;
        checkCount++;
        if (r !== modelAcc) $display("[TB] FAIL stall_result got=%h want=%h", r, modelAcc);
        else passCount++;
        applyStimulus(2'b10, '0, '0, 0, -1, 1'b0, dc, dn, bc, r, st);
        checkCount++;
        if (r !== modelAcc) $display("[TB] FAIL stall_single_update got=%h want=%h", r, modelAcc);
        else passCount++;
    endtask

    // Random mix of requests with operand noise after accept
    task automatic test_random();
        int dc, dn, bc, stall, wantLat;
        logic [XLEN-1:0] r, a, b;
        logic [1:0] op;
        bit st;
        for (int i = 0; i < 10; i++) begin
            op    = 2'($urandom_range(0, 3));
            if (i < 4) op = 2'b00;
            a     = {$urandom, $urandom};
            b     = {$urandom, $urandom};
            stall = $urandom_range(0, 2);
            applyStimulus(op, a, b, stall, -1, 1'b1, dc, dn, bc, r, st);
            if (op == 2'b00) modelAcc = modelAcc + a * b;
            else if (op == 2'b01) modelAcc = '0;
            wantLat = (op == 2'b00) ? N + 2 : 1;
            checkCount++;
            if (r !== modelAcc || dc !== wantLat || dn !== stall + 1)
                $display("[TB] FAIL random[%0d] op=%0d got=%h lat=%0d done=%0d want=%h lat=%0d done=%0d",
                         i, op, r, dc, dn, modelAcc, wantLat, stall + 1);
            else passCount++;
        end
    endtask

    // Reset in ACC discards everything; CLR after a MAC reads back zero
    task automatic test_reset_acc();
        int dc, dn, bc;
        logic [XLEN-1:0] r;
        bit st;
        bus.ValidE = 1'b1;
        bus.OpE    = 2'b00;
        bus.SrcAE  = {$urandom, $urandom};
        bus.SrcBE  = {$urandom, $urandom};
        for (int c = 0; c < N + 1; c++) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        checkCount++;
        if (bus.BusyE !== 1'b1 || bus.DoneE !== 1'b0)
            $display("[TB] FAIL acc_phase busy=%b done=%b want busy=1 done=0", bus.BusyE, bus.DoneE);
        else passCount++;
        #1;
        reset      = 1'b1;
        bus.ValidE = 1'b0;
        #1;
        checkCount++;
        if (bus.BusyE !== 1'b0 || bus.DoneE !== 1'b0 || bus.MacResultE !== '0)
            $display("[TB] FAIL async_reset busy=%b done=%b result=%h want 0/0/0",
                     bus.BusyE, bus.DoneE, bus.MacResultE);
        else passCount++;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        modelAcc = '0;
        applyStimulus(2'b10, '0, '0, 0, -1, 1'b0, dc, dn, bc, r, st);
        checkCount++;
        if (r !== modelAcc) $display("[TB] FAIL rd_after_reset_acc got=%h want=%h", r, modelAcc);
        else passCount++;
        applyStimulus(2'b00, {$urandom, $urandom}, {$urandom, $urandom}, 0, -1, 1'b0, dc, dn, bc, r, st);
        applyStimulus(2'b01, '0, '0, 0, -1, 1'b0, dc, dn, bc, r, st);
        modelAcc = '0;
        checkCount++;
        if (r !== modelAcc || dc !== 1)
            $display("[TB] FAIL clr_after_mac got=%h@%0d want=%h@1", r, dc, modelAcc);
        else passCount++;
    endtask

    // Scenario sequence and summary
    initial begin
        test_reset();
        test_mac_sequence();
        test_wrap();
        test_flush();
        test_stall();
        test_random();
        test_reset_acc();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
